// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Purpose: definitions shared by the stopwatch controller and its BCD
//          counter: the controller state encoding, the mod-60 digit limits
//          and the digit widths.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    ADJUST = 2'd2
  } state_t;

  localparam int MAX_TENS = 5;
  localparam int MAX_ONES = 9;

  localparam int TENS_W = 3;
  localparam int ONES_W = 4;

endpackage

// File: rtl/bcd_mod60.sv
// bcd_mod60
// Purpose: two-digit BCD counter that wraps from 59 to 00. It is used for
//          both the seconds field and the minutes field of the stopwatch.
// Ports:
//   clkDis   - display-domain clock, rising edge
//   clr      - synchronous clear to 00; has priority over inc
//   inc      - count up by one on this edge
//   tens     - registered tens digit, 0..MAX_TENS
//   ones     - registered ones digit, 0..MAX_ONES
//   carryOut - high when inc is asserted while the count is 59, so the
//              next field up can advance on the same edge
module bcd_mod60
  import stopwatch_pkg::*;
(
  input  logic              clkDis,
  input  logic              clr,
  input  logic              inc,
  output logic [TENS_W-1:0] tens,
  output logic [ONES_W-1:0] ones,
  output logic              carryOut
);

  logic [TENS_W-1:0] r_tens;
  logic [ONES_W-1:0] r_ones;
  logic              w_onesMax;
  logic              w_tensMax;

  assign w_onesMax = (r_ones == ONES_W'(MAX_ONES));
  assign w_tensMax = (r_tens == TENS_W'(MAX_TENS));
  assign carryOut  = inc & w_onesMax & w_tensMax;

  // Ones digit wraps 9->0 and bumps the tens digit; tens wraps 5->0.
  always_ff @(posedge clkDis) begin
    if (clr) begin
      r_tens <= '0;
      r_ones <= '0;
    end else if (inc) begin
      if (w_onesMax) begin
        r_ones <= '0;
        r_tens <= w_tensMax ? '0 : r_tens + 1'b1;
      end else begin
        r_ones <= r_ones + 1'b1;
      end
    end
  end

  assign tens = r_tens;
  assign ones = r_ones;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Purpose: sequencing controller for the stopwatch. It runs the
//          RUN/PAUSED/ADJUST state machine, owns the MM:SS digits and
//          produces the blank strobes that make the adjusted field blink.
// Ports:
//   clkDis   - display-domain clock, rising edge
//   rst      - synchronous active-high reset, also the user reset pulse
//   pauseP   - one-cycle pause event, toggles the pause flag
//   tick1hz  - normal count enable pulse
//   tick2hz  - adjust increment and blink pulse
//   adj      - adjust-mode switch level
//   sel      - adjust field select (0 = minutes, 1 = seconds)
//   m10/m1   - minutes tens/ones digits
//   s10/s1   - seconds tens/ones digits
//   paused   - pause flag
//   blankMin - blank the minutes digits this cycle
//   blankSec - blank the seconds digits this cycle
module stopwatch_ctrl
  import stopwatch_pkg::*;
(
  input  logic              clkDis,
  input  logic              rst,
  input  logic              pauseP,
  input  logic              tick1hz,
  input  logic              tick2hz,
  input  logic              adj,
  input  logic              sel,
  output logic [TENS_W-1:0] m10,
  output logic [ONES_W-1:0] m1,
  output logic [TENS_W-1:0] s10,
  output logic [ONES_W-1:0] s1,
  output logic              paused,
  output logic              blankMin,
  output logic              blankSec
);

  state_t r_state;
  state_t w_stateNext;
  logic   r_paused;
  logic   w_pausedNext;
  logic   r_phase;
  logic   w_phaseNext;
  logic   w_secInc;
  logic   w_minInc;
  logic   w_secCarry;

  // State, pause flag and blink phase registers.
  always_ff @(posedge clkDis) begin
    if (rst) begin
      r_state  <= RUN;
      r_paused <= 1'b0;
      r_phase  <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_paused <= w_pausedNext;
      r_phase  <= w_phaseNext;
    end
  end

  // Outside ADJUST the state simply mirrors the next pause flag. This keeps
  // RUN/PAUSED consistent with the flag even when pauseP arrives in ADJUST.
  // The blink phase only toggles while already in ADJUST. It is cleared
  // whenever the next state is not ADJUST, so no stray blank appears in the
  // first cycle after leaving adjust mode.
  always_comb begin
    w_pausedNext = r_paused ^ pauseP;
    w_stateNext  = w_pausedNext ? PAUSED : RUN;
    w_phaseNext  = 1'b0;
    w_secInc     = 1'b0;
    w_minInc     = 1'b0;
    if (adj) begin
      w_stateNext = ADJUST;
    end
    unique case (r_state)
      RUN: begin
        w_secInc = tick1hz;
        w_minInc = w_secCarry;
      end
      ADJUST: begin
        w_secInc = tick2hz & sel;
        w_minInc = tick2hz & ~sel;
        if (w_stateNext == ADJUST) begin
          w_phaseNext = r_phase ^ tick2hz;
        end
      end
      default: begin
      end
    endcase
  end

  bcd_mod60 u_sec (
    .clkDis   (clkDis),
    .clr      (rst),
    .inc      (w_secInc),
    .tens     (s10),
    .ones     (s1),
    .carryOut (w_secCarry)
  );

  // Minutes wrap silently; the stopwatch has no hours field.
  bcd_mod60 u_min (
    .clkDis   (clkDis),
    .clr      (rst),
    .inc      (w_minInc),
    .tens     (m10),
    .ones     (m1),
    .carryOut ()
  );

  assign paused   = r_paused;
  assign blankMin = r_phase & ~sel;
  assign blankSec = r_phase & sel;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
// Purpose: directed self-checking bench for stopwatch_ctrl. It walks the
//          count, carry, pause, adjust, blink and reset scenarios, using
//          hand-computed MM:SS values.
module tb_stopwatch_ctrl;

  logic       clkDis;
  logic       rst;
  logic       pauseP;
  logic       tick1hz;
  logic       tick2hz;
  logic       adj;
  logic       sel;
  logic [2:0] m10;
  logic [3:0] m1;
  logic [2:0] s10;
  logic [3:0] s1;
  logic       paused;
  logic       blankMin;
  logic       blankSec;

  int nChecks = 0;
  int nFails  = 0;

  stopwatch_ctrl dut (
    .clkDis   (clkDis),
    .rst      (rst),
    .pauseP   (pauseP),
    .tick1hz  (tick1hz),
    .tick2hz  (tick2hz),
    .adj      (adj),
    .sel      (sel),
    .m10      (m10),
    .m1       (m1),
    .s10      (s10),
    .s1       (s1),
    .paused   (paused),
    .blankMin (blankMin),
    .blankSec (blankSec)
  );

  // 100 MHz-style free-running clock.
  initial clkDis = 1'b0;
  always #5 clkDis = ~clkDis;

  // Digits folded into a decimal MMSS number for readable comparisons.
  function automatic int mmss();
    return int'(m10) * 1000 + int'(m1) * 100 + int'(s10) * 10 + int'(s1);
  endfunction

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Presents one cycle of pulses, then clears them 1 time unit after the edge
  // so that outputs are sampled away from the active edge.
  task automatic applyStimulus(input logic p, input logic t1, input logic t2);
    pauseP  = p;
    tick1hz = t1;
    tick2hz = t2;
    @(posedge clkDis);
    #1;
    pauseP  = 1'b0;
    tick1hz = 1'b0;
    tick2hz = 1'b0;
  endtask

  task automatic ticks1(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0);
  endtask

  task automatic ticks2(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst     = 1'b1;
    pauseP  = 1'b0;
    tick1hz = 1'b0;
    tick2hz = 1'b0;
    adj     = 1'b0;
    sel     = 1'b0;

    // Reset held two cycles, then three normal ticks.
    repeat (2) @(posedge clkDis);
    #1;
    checkOutput("reset_digits", mmss(), 0);
    checkOutput("reset_paused", int'(paused), 0);
    checkOutput("reset_blankMin", int'(blankMin), 0);
    checkOutput("reset_blankSec", int'(blankSec), 0);
    rst = 1'b0;
    ticks1(3);
    checkOutput("run_3ticks", mmss(), 3);
    checkOutput("run_paused", int'(paused), 0);
    checkOutput("run_blanks", int'(blankMin | blankSec), 0);

    // Preload 59:58 through adjust mode, then count across the full rollover.
    adj = 1'b1;
    sel = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    ticks2(59);
    checkOutput("adj_min_59", mmss(), 5903);
    sel = 1'b1;
    ticks2(55);
    checkOutput("adj_preload", mmss(), 5958);
    adj = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("exit_adj_blanks", int'(blankMin | blankSec), 0);
    ticks1(1);
    checkOutput("run_5959", mmss(), 5959);
    ticks1(1);
    checkOutput("run_wrap_0000", mmss(), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("run_no_extra", mmss(), 0);

    // Pause holds the digits, and a second pause resumes counting.
    ticks1(5);
    checkOutput("run_0005", mmss(), 5);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("pause_on", int'(paused), 1);
    ticks1(4);
    checkOutput("paused_hold", mmss(), 5);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("pause_off", int'(paused), 0);
    ticks1(1);
    checkOutput("resume_0006", mmss(), 6);

    // Adjust seconds from 00:06 up to 00:58, then across the 59->00 wrap.
    adj = 1'b1;
    sel = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    ticks2(52);
    checkOutput("adj_sec_0058", mmss(), 58);
    checkOutput("adj_phase_even", int'(blankSec), 0);
    ticks2(1);
    checkOutput("adjs_0059", mmss(), 59);
    checkOutput("blinkSec_1", int'(blankSec), 1);
    ticks2(1);
    checkOutput("adjs_wrap_0000", mmss(), 0);
    checkOutput("blinkSec_0", int'(blankSec), 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("adj_ignores_1hz", mmss(), 0);
    ticks2(1);
    checkOutput("adjs_0001", mmss(), 1);
    checkOutput("blinkSec_1b", int'(blankSec), 1);
    checkOutput("blinkMin_0", int'(blankMin), 0);

    // Move to 59:10, then wrap the minutes field with no carry out.
    ticks2(9);
    checkOutput("adjs_0010", mmss(), 10);
    sel = 1'b0;
    ticks2(59);
    checkOutput("adjm_5910", mmss(), 5910);
    checkOutput("blinkMin_1", int'(blankMin), 1);
    ticks2(1);
    checkOutput("adjm_wrap_0010", mmss(), 10);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("adj_pause_toggle", int'(paused), 1);
    adj = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("exit_to_paused", int'(paused), 1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("paused_holds", mmss(), 10);
    checkOutput("paused_blanks", int'(blankMin | blankSec), 0);

    // Resume, set 00:09, then send pauseP and tick1hz in the same cycle.
    applyStimulus(1'b1, 1'b0, 1'b0);
    ticks1(1);
    checkOutput("resumed_0011", mmss(), 11);
    adj = 1'b1;
    sel = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    ticks2(58);
    checkOutput("adjs_0009", mmss(), 9);
    adj = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("same_cycle_count", mmss(), 10);
    checkOutput("same_cycle_pause", int'(paused), 1);
    ticks1(1);
    checkOutput("after_same_hold", mmss(), 10);

    // A tick coinciding with adj rising still counts.
    applyStimulus(1'b1, 1'b0, 1'b0);
    adj = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("adj_rise_tick", mmss(), 11);

    // Reset during adjust, with a simultaneous tick2hz.
    sel = 1'b0;
    ticks2(1);
    checkOutput("pre_rst_blinkMin", int'(blankMin), 1);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("rst_adj_digits", mmss(), 0);
    checkOutput("rst_adj_paused", int'(paused), 0);
    checkOutput("rst_adj_blanks", int'(blankMin | blankSec), 0);
    rst = 1'b0;
    adj = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    ticks1(1);
    checkOutput("rst_back_to_run", mmss(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the stopwatch: consumes the one-cycle debounced pause and reset events plus the 1 Hz and 2 Hz tick pulses, and owns the four BCD time digits. It runs a RUN/PAUSED/ADJUST state machine, advances MM:SS in normal counting, and increments the selected field in adjust mode. It also drives per-field blank strobes so the display mux can blink the field being adjusted. It sits between the debouncer/clock-divider and the seven-segment display driver.

## Interface
- MAX_TENS, 5: upper tens digit for both fields (mod-60).
- MAX_ONES, 9: upper ones digit.
- clkDis  in  1  display-domain clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high; also the debounced user reset pulse.
- pauseP  in  1  one-cycle debounced pause event; toggles pause.
- tick1hz  in  1  one-cycle pulse, normal count enable.
- tick2hz  in  1  one-cycle pulse, adjust increment and blink rate.
- adj  in  1  adjust-mode switch level (1 = ADJUST).
- sel  in  1  adjust field select level (0 = minutes, 1 = seconds).
- m10  out  3  minutes tens, 0..5.
- m1  out  4  minutes ones, 0..9.
- s10  out  3  seconds tens, 0..5.
- s1  out  4  seconds ones, 0..9.
- paused  out  1  pause flag.
- blankMin  out  1  blank minutes digits this cycle.
- blankSec  out  1  blank seconds digits this cycle.

## Operation
- States: RUN, PAUSED, ADJUST. Reset → RUN; all digits 0, paused=0, blink phase=0, blankMin=blankSec=0.
- adj=1 from any state → ADJUST next cycle. adj=0 in ADJUST → RUN if paused=0, else PAUSED.
- pauseP toggles paused in every state, including ADJUST. The flag persists across ADJUST. RUN↔PAUSED follows paused.
- RUN, tick1hz: s1+1; 9→0 carries to s10; s10 5→0 carries to m1; m1 9→0 carries to m10; 59:59 → 00:00.
- PAUSED: digits hold; ticks ignored.
- ADJUST, tick2hz: the selected field increments mod 60 with no carry out. Seconds 59→00 leaves minutes unchanged, and minutes 59→00 wraps. tick1hz is ignored.
- ADJUST blink: blink phase toggles on each tick2hz. blankMin = phase & ~sel; blankSec = phase & sel. Outside ADJUST, the phase is forced to 0 and both blanks are 0.
- sel changes mid-ADJUST: the new field is used from the next tick2hz. Blanking follows sel combinationally from the registered phase.
- Simultaneous pauseP + tick1hz in RUN: the tick counts using the pre-toggle state, and the pause takes effect the next cycle.
- Simultaneous adj rise + tick1hz in RUN: the tick counts, and ADJUST starts the next cycle.
- rst dominates every other input in the same cycle, including mid-adjust and mid-carry.

## Timing
- Every output is registered, except the blank AND gating from the registered phase and sel.
- Digit update: tick sampled on edge N, new digits visible after edge N; one-cycle latency.
- State change latency: one cycle after an adj level change or a pauseP pulse.
- Tick inputs are assumed at most one cycle wide. A pulse held longer counts once per cycle.
- Digits never leave the legal range. Out-of-range values are unreachable from reset.

## Structure
- Shared package stopwatch_pkg holds:
  - state enum (RUN, PAUSED, ADJUST);
  - MAX_TENS and MAX_ONES;
  - digit width constants (TENS_W=3, ONES_W=4).
- One sub-module, bcd_mod60: holds a two-digit tens/ones register and has ports `inc`, `clr`, `carryOut`. carryOut=1 when inc=1 at 59. It is instantiated twice (seconds, minutes). The controller gates minute inc with the seconds carry only in RUN.

## Test plan
- rst held 2 cycles, then 3 tick1hz → 00:03, paused=0, blanks 0.
- Preload 59:58 via adjust, return to RUN, 2 tick1hz → 59:59, then 00:00; no extra carry.
- RUN at 00:05, pauseP, 4 tick1hz → stays 00:05, paused=1. pauseP again, 1 tick1hz → 00:06.
- adj=1, sel=1 at 00:58, 3 tick2hz → 00:01 (minutes unchanged); blankSec toggles 1,0,1; blankMin stays 0.
- adj=1, sel=0 at 59:10, 1 tick2hz → 00:10. Drop adj while paused=1 → PAUSED, digits hold.
- Same-cycle pauseP + tick1hz at 00:09 → 00:10, paused=1. rst during ADJUST → 00:00, RUN, blanks 0.
